hadamard_sweep_ctrl: RTL and testbench
======================================

// Module: hadamard_sweep_ctrl
// PURPOSE
//  Initiator side of the HROOT go/done handshake. Holds a 2^NQ real-amplitude state vector of IEEE-754
//  singles and applies a single-qubit gate to target qubit T. It walks every amplitude pair (i0, i1 = i0|1<<T),
//  issues each pair to the gate unit, waits for done, and writes the results back in place.
//  Sits between the host/test sequencer and one HROOT instance.
// PARAMETERS
//  NQ       3     number of qubits; state vector depth 2^NQ, pair count 2^(NQ-1); NQ>=1
//  W        32    amplitude width (IEEE-754 single bit pattern, not interpreted)
//  TIMEOUT  64    max cycles from gate_go to gate_done before abort
// PORTS
//  clk           in   1      rising-edge clock, sole clock domain
//  reset         in   1      synchronous, active-high
//  load_we       in   1      write load_data into amp[load_addr]; honoured only when idle
//  load_addr     in   NQ     amplitude index for load
//  load_data     in   W      amplitude bit pattern
//  start         in   1      begin sweep on target; honoured only when idle
//  target        in   clog2(NQ)+1  qubit index, sampled on start
//  rd_addr       in   NQ     readout index
//  rd_data       out  W      amp[rd_addr], registered, 1-cycle latency
//  busy          out  1      sweep in progress
//  finished      out  1      1-cycle pulse, sweep completed OK
//  err           out  1      1-cycle pulse: bad target or timeout
//  gate_up       out  W      |0> amplitude of current pair, held stable from go until done
//  gate_down     out  W      |1> amplitude of current pair
//  gate_go       out  1      1-cycle request pulse
//  gate_upout    in   W      result |0>, valid when gate_done=1
//  gate_downout  in   W      result |1>, valid when gate_done=1
//  gate_done     in   1      result strobe from gate unit
//  gate_running  in   1      gate unit busy; go is never issued while high
// BEHAVIOUR
//  Reset: amp[0]=32'h3f800000 (|0..0>=1.0), all other amp=0. Outputs busy/finished/err/gate_go=0,
//   gate_up/gate_down=0, rd_data=0. FSM->IDLE, pair counter k=0.
//  Reset mid-sweep aborts immediately. Partially written amplitudes are discarded (vector re-initialised).
//  FSM: IDLE -> ISSUE -> WAIT -> WRBK -> (ISSUE | FIN) -> IDLE.
//  IDLE: start with target<NQ: latch T, k=0, busy=1 next cycle, ->ISSUE.
//   start with target>=NQ: err pulse next cycle, stay IDLE, vector unchanged.
//   load_we in IDLE writes the same cycle; load_we while busy is ignored. start while busy is ignored.
//   load_we and start in the same cycle: the write takes effect and the sweep sees the new value.
//  Pair index: i0 = k with a 0 bit inserted at position T; i1 = i0 | (1<<T). k runs 0..2^(NQ-1)-1 ascending.
//  ISSUE: wait while gate_running=1; else drive gate_up=amp[i0], gate_down=amp[i1], gate_go=1 for exactly one cycle.
//   Start timeout counter, ->WAIT.
//  WAIT: on gate_done=1 capture gate_upout/gate_downout, ->WRBK. gate_done in the same cycle as go is ignored.
//   If the counter reaches TIMEOUT: err pulse, busy=0, ->IDLE. Pairs already written stay written.
//  WRBK: amp[i0]=captured up, amp[i1]=captured down (one cycle). If k is last ->FIN, else k++ ->ISSUE.
//  FIN: finished=1 for one cycle, busy drops in the same cycle, ->IDLE.
//  Min cycles per pair = 3 + gate latency. Spurious gate_done in IDLE/ISSUE/WRBK is ignored.
//  rd_data reflects writes from the previous cycle onward; readout is legal while busy (observes intermediate state).
// TESTING  (bench HROOT stub: done 4 cycles after go, returns up'=down, down'=up)
//  1 reset, read all addrs -> amp[0]=3f800000, rest 00000000; busy=0.
//  2 NQ=3, load amp[i]=i, start T=1 -> 4 go pulses with pairs (0,2),(1,3),(4,6),(5,7);
//    final amp={2,3,0,1,6,7,4,5}; one finished pulse.
//  3 start target=3 (NQ=3) -> err pulse, no gate_go, vector unchanged.
//  4 stub never asserts done -> err exactly TIMEOUT=64 cycles after go, busy=0, FSM idle.
//  5 hold gate_running=1 for 10 cycles at sweep start -> first go delayed until it drops; load_we during the sweep ignored.
//  6 reset asserted during the 2nd pair's WAIT -> next cycle busy=0, amp[0]=3f800000, amp[1..7]=0.

Source files
------------

// File: rtl/hadamard_sweep_ctrl.sv
// Sweeps every amplitude pair of a 2^NQ state vector through an external gate unit
// over a go/done handshake and writes the results back in place.
module hadamard_sweep_ctrl #(
  parameter int unsigned NQ      = 3,
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_we,
  input  logic [NQ-1:0]            load_addr,
  input  logic [W-1:0]             load_data,
  input  logic                     start,
  input  logic [$clog2(NQ):0]      target,
  input  logic [NQ-1:0]            rd_addr,
  output logic [W-1:0]             rd_data,
  output logic                     busy,
  output logic                     finished,
  output logic                     err,
  output logic [W-1:0]             gate_up,
  output logic [W-1:0]             gate_down,
  output logic                     gate_go,
  input  logic [W-1:0]             gate_upout,
  input  logic [W-1:0]             gate_downout,
  input  logic                     gate_done,
  input  logic                     gate_running
);

  localparam int unsigned TW    = $clog2(NQ) + 1;
  localparam int unsigned DEPTH = 2 ** NQ;
  localparam int unsigned CW    = $clog2(TIMEOUT + 1);
  localparam logic [NQ-1:0] LAST_K  = NQ'(2 ** (NQ - 1) - 1);
  localparam logic [W-1:0]  ONE_AMP = W'(32'h3f80_0000);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRBK,
    S_FIN
  } state_t;

  state_t        state, state_n;
  logic [NQ-1:0] k, k_n;
  logic [TW-1:0] t, t_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [W-1:0]  cap_up, cap_up_n, cap_down, cap_down_n;
  logic [W-1:0]  gate_up_n, gate_down_n;
  logic          gate_go_n, busy_n, finished_n, err_n;
  logic [NQ-1:0] low_mask, i0, i1;
  logic [W-1:0]  amp [DEPTH];

  // Pair addresses: k with a zero bit inserted at the target position, and its partner.
  always_comb begin
    low_mask = (NQ'(1) << t) - NQ'(1);
    i0       = ((k & ~low_mask) << 1) | (k & low_mask);
    i1       = i0 | (NQ'(1) << t);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      k        <= '0;
      t        <= '0;
      cnt      <= '0;
      cap_up   <= '0;
      cap_down <= '0;
      gate_up  <= '0;
      gate_down <= '0;
      gate_go  <= 1'b0;
      busy     <= 1'b0;
      finished <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      k        <= k_n;
      t        <= t_n;
      cnt      <= cnt_n;
      cap_up   <= cap_up_n;
      cap_down <= cap_down_n;
      gate_up  <= gate_up_n;
      gate_down <= gate_down_n;
      gate_go  <= gate_go_n;
      busy     <= busy_n;
      finished <= finished_n;
      err      <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    k_n         = k;
    t_n         = t;
    cnt_n       = cnt;
    cap_up_n    = cap_up;
    cap_down_n  = cap_down;
    gate_up_n   = gate_up;
    gate_down_n = gate_down;
    gate_go_n   = 1'b0;
    busy_n      = busy;
    finished_n  = 1'b0;
    err_n       = 1'b0;
    case (state)
      S_IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          if (target < TW'(NQ)) begin
            t_n     = target;
            k_n     = '0;
            busy_n  = 1'b1;
            state_n = S_ISSUE;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (!gate_running) begin
          gate_up_n   = amp[i0];
          gate_down_n = amp[i1];
          gate_go_n   = 1'b1;
          cnt_n       = '0;
          state_n     = S_WAIT;
        end
      end
      S_WAIT: begin
        // A done coinciding with our own go pulse belongs to nothing we issued.
        if (gate_done && !gate_go) begin
          cap_up_n   = gate_upout;
          cap_down_n = gate_downout;
          state_n    = S_WRBK;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_WRBK: begin
        if (k == LAST_K) begin
          state_n = S_FIN;
        end else begin
          k_n     = k + NQ'(1);
          state_n = S_ISSUE;
        end
      end
      S_FIN: begin
        finished_n = 1'b1;
        busy_n     = 1'b0;
        state_n    = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State vector: host loads only while idle, write-back owns it during a sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        amp[i] <= (i == 0) ? ONE_AMP : '0;
      end
    end else if (state == S_IDLE && load_we) begin
      amp[load_addr] <= load_data;
    end else if (state == S_WRBK) begin
      amp[i0] <= cap_up;
      amp[i1] <= cap_down;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= amp[rd_addr];
    end
  end

endmodule

// File: tb/tb_hadamard_sweep_ctrl.sv
// Scoreboard bench for hadamard_sweep_ctrl with a swapping gate-unit stub.
module tb_hadamard_sweep_ctrl;

  localparam int NQ    = 3;
  localparam int DEPTH = 8;
  localparam int TO    = 64;

  typedef struct {
    logic [31:0] up;
    logic [31:0] dn;
  } pair_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_we = 1'b0;
  logic [2:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        start = 1'b0;
  logic [2:0]  target = '0;
  logic [2:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        busy, finished, err;
  logic [31:0] gate_up, gate_down;
  logic        gate_go;
  logic [31:0] gate_upout = '0, gate_downout = '0;
  logic        gate_done = 1'b0;
  logic        gate_running;
  logic        run_force = 1'b0;
  logic        hang = 1'b0;

  always #5 clk = ~clk;

  hadamard_sweep_ctrl #(.NQ(NQ), .W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .start(start), .target(target),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .finished(finished), .err(err),
    .gate_up(gate_up), .gate_down(gate_down), .gate_go(gate_go),
    .gate_upout(gate_upout), .gate_downout(gate_downout),
    .gate_done(gate_done), .gate_running(gate_running)
  );

  assign gate_running = run_force;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_go    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Gate stub: done 4 cycles after go, returns the pair swapped; hang suppresses done.
  int          cd = 0;
  logic [31:0] lat_up = '0, lat_dn = '0;
  always @(posedge clk) begin
    gate_done <= 1'b0;
    if (reset) begin
      cd <= 0;
    end else if (gate_go) begin
      cd     <= 3;
      lat_up <= gate_up;
      lat_dn <= gate_down;
    end else if (cd > 0) begin
      cd <= cd - 1;
      if (cd == 1 && !hang) begin
        gate_done    <= 1'b1;
        gate_upout   <= lat_dn;
        gate_downout <= lat_up;
      end
    end
  end

  // Scoreboard queues and monitor.
  pair_t       goq[$];
  int          evq[$];
  logic [31:0] rdq[$];
  logic        rd_req = 1'b0, rd_vld = 1'b0;
  logic [31:0] held_up = '0, held_dn = '0;
  pair_t       mp;
  int          mcode;

  always @(posedge clk) rd_vld <= rd_req;

  always @(negedge clk) begin
    if (!reset) begin
      if (gate_go) begin
        n_go++;
        held_up = gate_up;
        held_dn = gate_down;
        if (goq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_go: got up=%h down=%h expected no request", gate_up, gate_down);
        end else begin
          mp = goq.pop_front();
          check("go_up", gate_up, mp.up);
          check("go_down", gate_down, mp.dn);
        end
      end
      if (gate_done && busy) begin
        check("held_up", gate_up, held_up);
        check("held_down", gate_down, held_dn);
      end
      if (finished || err) begin
        mcode = (finished ? 1 : 0) + (err ? 2 : 0);
        if (evq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event: got code %0d expected none", mcode);
        end else begin
          check("event", 32'(mcode), 32'(evq.pop_front()));
        end
      end
      if (rd_vld) begin
        if (rdq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rd: got %h expected no read", rd_data);
        end else begin
          check("rd_data", rd_data, rdq.pop_front());
        end
      end
    end
  end

  // Reference vector.
  logic [31:0] mem [DEPTH];

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = (i == 0) ? 32'h3f80_0000 : 32'h0;
  endtask

  task automatic readback();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      rd_addr = 3'(i);
      rd_req  = 1'b1;
      rdq.push_back(mem[i]);
    end
    @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_vec(input bit seq);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      load_we   = 1'b1;
      load_addr = 3'(i);
      load_data = seq ? 32'(i) : $urandom;
      mem[i]    = load_data;
    end
    @(negedge clk);
    load_we = 1'b0;
  endtask

  // Expected go order: ascending indices with the target bit clear, paired with their partners.
  task automatic push_pairs(input int t, input int npairs);
    int n = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((i >> t) & 1) == 0 && n < npairs) begin
        goq.push_back('{up: mem[i], dn: mem[i | (1 << t)]});
        n++;
      end
    end
  endtask

  task automatic sweep(input int t, input int hold, input bit inject);
    int w;
    logic [31:0] nxt [DEPTH];
    push_pairs(t, DEPTH / 2);
    evq.push_back(1);
    @(negedge clk);
    start     = 1'b1;
    target    = 3'(t);
    run_force = (hold > 0);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    if (inject) begin
      load_we   = 1'b1;
      load_addr = 3'd0;
      load_data = 32'hdead_beef;
      @(negedge clk);
      load_we = 1'b0;
    end
    if (hold > 0) begin
      for (int c = 0; c < hold; c++) begin
        check("no_go_while_running", gate_go, 0);
        @(negedge clk);
      end
      run_force = 1'b0;
      @(negedge clk);
      check("go_after_release", gate_go, 1);
    end
    w = 0;
    while (!finished && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("sweep_finished", finished, 1);
    check("busy_at_finish", busy, 0);
    for (int i = 0; i < DEPTH; i++) nxt[i] = mem[i ^ (1 << t)];
    for (int i = 0; i < DEPTH; i++) mem[i] = nxt[i];
    readback();
  endtask

  task automatic bad_target(input int tb_t);
    evq.push_back(2);
    @(negedge clk);
    start  = 1'b1;
    target = 3'(tb_t);
    @(negedge clk);
    start = 1'b0;
    check("bad_target_err", err, 1);
    check("bad_target_busy", busy, 0);
    repeat (3) @(negedge clk);
    readback();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected $finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, g;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_finished", finished, 0);
    check("rst_err", err, 0);
    check("rst_go", gate_go, 0);
    check("rst_gate_up", gate_up, 0);
    check("rst_gate_down", gate_down, 0);
    check("rst_rd_data", rd_data, 0);
    reset = 1'b0;
    readback();

    // Sequential vector, target 1.
    load_vec(1'b1);
    sweep(1, 0, 1'b0);

    bad_target(3);

    // Gate never answers: abort exactly TIMEOUT cycles after go.
    load_vec(1'b0);
    hang = 1'b1;
    push_pairs(2, 1);
    evq.push_back(2);
    @(negedge clk);
    start  = 1'b1;
    target = 3'd2;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!gate_go && w < 50) begin @(negedge clk); w++; end
    check("timeout_go_seen", gate_go, 1);
    g = cyc;
    w = 0;
    while (!err && w < 200) begin @(negedge clk); w++; end
    check("timeout_err", err, 1);
    check("timeout_cycles", 32'(cyc - g), 32'(TO));
    check("timeout_busy", busy, 0);
    hang = 1'b0;
    repeat (8) @(negedge clk);
    readback();

    // Gate busy at sweep start plus an ignored load during the sweep.
    load_vec(1'b0);
    sweep(0, 10, 1'b1);

    for (int r = 0; r < 6; r++) begin
      if ($urandom_range(0, 1) == 1) load_vec(1'b0);
      sweep(int'($urandom_range(0, 2)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) bad_target(int'($urandom_range(3, 7)));
    end

    // Reset during the second pair's wait.
    load_vec(1'b0);
    push_pairs(1, 2);
    g = n_go;
    @(negedge clk);
    start  = 1'b1;
    target = 3'd1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (n_go < g + 2 && w < 100) begin @(negedge clk); w++; end
    check("second_go_seen", 32'(n_go - g), 2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_mid_busy", busy, 0);
    check("reset_mid_go", gate_go, 0);
    model_reset();
    repeat (6) @(negedge clk);
    readback();

    repeat (4) @(negedge clk);
    check("goq_drained", 32'(goq.size()), 0);
    check("evq_drained", 32'(evq.size()), 0);
    check("rdq_drained", 32'(rdq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
